// File: rtl/demux1x4_lanes.sv
// Round-robin byte demultiplexer: one byte stream in, four lanes out.
// Lanes 0..2 are staged; the fourth byte completes the group and all lanes update together.
module demux1x4_lanes #(
  parameter int BW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [BW-1:0] in,
  input  logic          valid_in,
  input  logic          align,
  output logic [BW-1:0] out0,
  output logic [BW-1:0] out1,
  output logic [BW-1:0] out2,
  output logic [BW-1:0] out3,
  output logic [3:0]    valid,
  output logic [7:0]    grp_cnt
);

  // Stream: a byte moves when valid_in is high on a rising edge; there is no
  // ready, so every qualified byte is taken. valid pulses 4'b1111 for one cycle per group.
  typedef enum logic [1:0] {COLLECT0, COLLECT1, COLLECT2, COLLECT3} state_t;

  state_t        state;
  logic [BW-1:0] stg0;
  logic [BW-1:0] stg1;
  logic [BW-1:0] stg2;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= COLLECT0;
      stg0    <= '0;
      stg1    <= '0;
      stg2    <= '0;
      out0    <= '0;
      out1    <= '0;
      out2    <= '0;
      out3    <= '0;
      valid   <= 4'b0000;
      grp_cnt <= 8'd0;
    end else begin
      valid <= 4'b0000;
      if (align) begin
        // A byte arriving with align opens the new group as lane 0.
        if (valid_in) begin
          stg0  <= in;
          state <= COLLECT1;
        end else begin
          state <= COLLECT0;
        end
      end else if (valid_in) begin
        case (state)
          COLLECT0: begin
            stg0  <= in;
            state <= COLLECT1;
          end
          COLLECT1: begin
            stg1  <= in;
            state <= COLLECT2;
          end
          COLLECT2: begin
            stg2  <= in;
            state <= COLLECT3;
          end
          COLLECT3: begin
            out0    <= stg0;
            out1    <= stg1;
            out2    <= stg2;
            out3    <= in;
            valid   <= 4'b1111;
            grp_cnt <= grp_cnt + 8'd1;
            state   <= COLLECT0;
          end
          default: state <= COLLECT0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_demux1x4_lanes.sv
// Bench for demux1x4_lanes: scenario tasks drive bytes and push expected groups;
// a negedge monitor pops on each emit and checks that lanes hold between emits.
module tb_demux1x4_lanes;

  localparam int BW = 8;
  localparam int W  = 4 * BW + 8;

  logic          clk;
  logic          reset;
  logic [BW-1:0] in;
  logic          valid_in;
  logic          align;
  logic [BW-1:0] out0;
  logic [BW-1:0] out1;
  logic [BW-1:0] out2;
  logic [BW-1:0] out3;
  logic [3:0]    valid;
  logic [7:0]    grp_cnt;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_seen;
  logic [7:0]   exp_grp;
  int           errors;
  int           checks;

  demux1x4_lanes #(.BW(BW)) dut (
    .clk      (clk),
    .reset    (reset),
    .in       (in),
    .valid_in (valid_in),
    .align    (align),
    .out0     (out0),
    .out1     (out1),
    .out2     (out2),
    .out3     (out3),
    .valid    (valid),
    .grp_cnt  (grp_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Scoreboard monitor: an emit must match the oldest expected group,
  // any other cycle must show valid low and the previous group held.
  always @(negedge clk) begin
    logic [W-1:0] got;
    logic [W-1:0] e;
    if (!reset) begin
      got = {out0, out1, out2, out3, grp_cnt};
      checks++;
      if (valid === 4'b1111) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL emit_extra: got lanes/grp=%h with no group expected", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL emit_data: got lanes/grp=%h expected %h", got, e);
          end
          last_seen = e;
        end
      end else if (valid !== 4'b0000 || got !== last_seen) begin
        errors++;
        $display("FAIL hold: valid=%b lanes/grp=%h expected valid=0000 lanes/grp=%h",
                 valid, got, last_seen);
      end
    end
  end

  task automatic send(input logic [BW-1:0] b, input logic v, input logic a);
    @(negedge clk);
    in       = b;
    valid_in = v;
    align    = a;
  endtask

  task automatic push_grp(input logic [BW-1:0] b0, input logic [BW-1:0] b1,
                          input logic [BW-1:0] b2, input logic [BW-1:0] b3);
    exp_grp = exp_grp + 8'd1;
    exp_q.push_back({b0, b1, b2, b3, exp_grp});
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    send('0, 1'b0, 1'b0);
    while (exp_q.size() != 0 && n < 12) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d groups never emitted, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset     = 1'b1;
    valid_in  = 1'b0;
    align     = 1'b0;
    in        = '0;
    exp_q.delete();
    last_seen = '0;
    exp_grp   = 8'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    #1;
    checks += 6;
    if (out0 !== 8'h00) begin errors++; $display("FAIL reset_out0: got %h expected 00", out0); end
    if (out1 !== 8'h00) begin errors++; $display("FAIL reset_out1: got %h expected 00", out1); end
    if (out2 !== 8'h00) begin errors++; $display("FAIL reset_out2: got %h expected 00", out2); end
    if (out3 !== 8'h00) begin errors++; $display("FAIL reset_out3: got %h expected 00", out3); end
    if (valid !== 4'b0000) begin errors++; $display("FAIL reset_valid: got %b expected 0000", valid); end
    if (grp_cnt !== 8'd0) begin errors++; $display("FAIL reset_grp_cnt: got %0d expected 0", grp_cnt); end
  endtask

  task automatic test_continuous();
    logic [BW-1:0] seq [8];
    seq = '{8'hFF, 8'hEE, 8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h99, 8'h88};
    push_grp(8'hFF, 8'hEE, 8'hDD, 8'hCC);
    push_grp(8'hBB, 8'hAA, 8'h99, 8'h88);
    for (int i = 0; i < 8; i++) send(seq[i], 1'b1, 1'b0);
    drain("continuous");
    checks++;
    if (grp_cnt !== 8'd2) begin errors++; $display("FAIL continuous_grp_cnt: got %0d expected 2", grp_cnt); end
  endtask

  task automatic test_gap();
    push_grp(8'h11, 8'h22, 8'h33, 8'h44);
    send(8'h11, 1'b1, 1'b0);
    send(8'h22, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) send(8'h5A, 1'b0, 1'b0);
    send(8'h33, 1'b1, 1'b0);
    send(8'h44, 1'b1, 1'b0);
    drain("gap");
  endtask

  task automatic test_align();
    push_grp(8'h0A, 8'h0B, 8'h0C, 8'h0D);
    send(8'h01, 1'b1, 1'b0);
    send(8'h02, 1'b1, 1'b0);
    send(8'h03, 1'b1, 1'b0);
    send(8'h0A, 1'b1, 1'b1);
    send(8'h0B, 1'b1, 1'b0);
    send(8'h0C, 1'b1, 1'b0);
    send(8'h0D, 1'b1, 1'b0);
    drain("align");
    // align with no byte, mid-group: the next four bytes form a fresh group
    push_grp(8'h21, 8'h22, 8'h23, 8'h24);
    send(8'h77, 1'b1, 1'b0);
    send(8'h78, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) send(8'h21 + 8'(i), 1'b1, 1'b0);
    drain("align_idle");
  endtask

  task automatic test_reset_mid_group();
    send(8'hE1, 1'b1, 1'b0);
    send(8'hE2, 1'b1, 1'b0);
    apply_reset();
    push_grp(8'h50, 8'h51, 8'h52, 8'h53);
    for (int i = 0; i < 4; i++) send(8'h50 + 8'(i), 1'b1, 1'b0);
    drain("reset_mid");
    checks++;
    if (grp_cnt !== 8'd1) begin errors++; $display("FAIL reset_mid_grp_cnt: got %0d expected 1", grp_cnt); end
  endtask

  task automatic test_wrap();
    logic [BW-1:0] b [4];
    apply_reset();
    for (int g = 0; g < 256; g++) begin
      for (int k = 0; k < 4; k++) b[k] = 8'($urandom_range(0, 255));
      push_grp(b[0], b[1], b[2], b[3]);
      for (int k = 0; k < 4; k++) send(b[k], 1'b1, 1'b0);
    end
    drain("wrap");
    checks++;
    if (grp_cnt !== 8'd0) begin errors++; $display("FAIL wrap_grp_cnt: got %0d expected 0", grp_cnt); end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    reset     = 1'b1;
    in        = '0;
    valid_in  = 1'b0;
    align     = 1'b0;
    last_seen = '0;
    exp_grp   = 8'd0;
    test_reset();
    test_continuous();
    test_gap();
    test_align();
    test_reset_mid_group();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
